// File: rtl/hybrid_loop_bht.sv
// Hybrid branch history table: bimodal counter + per-entry loop predictor + chooser.
// Define HYBRID_BHT_LOOP_PRED_EN to build the loop predictor and chooser; otherwise bimodal only.
module hybrid_loop_bht #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned VLEN            = 64,
  parameter int unsigned RVC             = 1,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned ARB_BITS        = 2,
  parameter int unsigned LOOP_BITS       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic                       init_done_o
);

  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned RAB       = $clog2(INSTR_PER_FETCH);
  localparam int unsigned SLOT_BITS = (RAB == 0) ? 1 : RAB;
  localparam int unsigned OFFSET    = (RVC != 0) ? 1 : 2;

  if (CTR_BITS < 2 || ARB_BITS < 2 || LOOP_BITS < 1 ||
      NR_ENTRIES < 2 * INSTR_PER_FETCH) begin : g_bad_cfg
    $error("hybrid_loop_bht: illegal parameter set");
  end

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_e;

  typedef struct packed {
    logic                 valid;
    logic [CTR_BITS-1:0]  ctr;
`ifdef HYBRID_BHT_LOOP_PRED_EN
    logic [ARB_BITS-1:0]  arb;
    logic [LOOP_BITS-1:0] trip;
    logic [LOOP_BITS-1:0] longest;
    logic                 longest_taken;
    logic                 last_taken;
`endif
  } entry_t;

  function automatic logic [ROW_BITS-1:0] row_of(input logic [VLEN-1:0] pc);
    return ROW_BITS'(pc >> (RAB + OFFSET));
  endfunction

  function automatic logic [SLOT_BITS-1:0] slot_of(input logic [VLEN-1:0] pc);
    if (RVC != 0) return SLOT_BITS'(pc >> OFFSET) & SLOT_BITS'(INSTR_PER_FETCH - 1);
    return '0;
  endfunction

  function automatic entry_t default_entry();
    entry_t e;
    e     = '0;
    e.ctr = CTR_BITS'(1) << (CTR_BITS - 1);
`ifdef HYBRID_BHT_LOOP_PRED_EN
    e.arb = ARB_BITS'((1 << (ARB_BITS - 1)) - 1);
`endif
    return e;
  endfunction

`ifdef HYBRID_BHT_LOOP_PRED_EN
  // Once a loop length is learned, flip direction exactly at the learned trip count.
  function automatic logic loop_pred(input entry_t e);
    if (e.last_taken == e.longest_taken && e.longest != '0)
      return (e.trip == e.longest) ? !e.longest_taken : e.longest_taken;
    return e.longest_taken;
  endfunction
`endif

  function automatic logic predict(input entry_t e);
`ifdef HYBRID_BHT_LOOP_PRED_EN
    logic bim;
    logic lp;
    bim = e.ctr[CTR_BITS-1];
    lp  = loop_pred(e);
    if (bim == lp) return bim;
    return e.arb[ARB_BITS-1] ? lp : bim;
`else
    return e.ctr[CTR_BITS-1];
`endif
  endfunction

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] sweep_q, sweep_d;
  entry_t              table_q [NR_ROWS][INSTR_PER_FETCH];

  logic [ROW_BITS-1:0]  pred_row;
  logic [ROW_BITS-1:0]  upd_row;
  logic [SLOT_BITS-1:0] upd_slot;
  logic                 upd_en;
  entry_t               upd_old;
  entry_t               upd_new;

  // State register and sweep pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next-state: sweep one row per cycle, flush restarts from row 0
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      S_INIT: begin
        if (flush_i) begin
          sweep_d = '0;
        end else if (sweep_q == ROW_BITS'(NR_ROWS - 1)) begin
          state_d = S_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + ROW_BITS'(1);
        end
      end
      S_READY: begin
        if (flush_i) begin
          state_d = S_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
      end
    endcase
  end

  assign init_done_o = (state_q == S_READY);

  // Zero-latency prediction; suppressed entirely while the table is being swept
  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    pred_row     = row_of(vpc_i);
    if (state_q == S_READY) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
        pred_valid_o[i] = table_q[pred_row][i].valid;
        pred_taken_o[i] = predict(table_q[pred_row][i]);
      end
    end
  end

  assign upd_row  = row_of(upd_pc_i);
  assign upd_slot = slot_of(upd_pc_i);
  assign upd_old  = table_q[upd_row][upd_slot];
  assign upd_en   = upd_valid_i && !debug_mode_i && (state_q == S_READY) && !flush_i && !rst_i;

  // Read-modify-write of the trained slot
  always_comb begin
`ifdef HYBRID_BHT_LOOP_PRED_EN
    logic upd_bim;
    logic upd_loop;
`endif
    upd_new       = upd_old;
    upd_new.valid = 1'b1;
    if (upd_taken_i) begin
      if (upd_old.ctr != '1) upd_new.ctr = upd_old.ctr + CTR_BITS'(1);
    end else begin
      if (upd_old.ctr != '0) upd_new.ctr = upd_old.ctr - CTR_BITS'(1);
    end
`ifdef HYBRID_BHT_LOOP_PRED_EN
    upd_bim  = upd_old.ctr[CTR_BITS-1];
    upd_loop = loop_pred(upd_old);
    if (upd_loop == upd_taken_i && upd_bim != upd_taken_i) begin
      if (upd_old.arb != '1) upd_new.arb = upd_old.arb + ARB_BITS'(1);
    end else if (upd_bim == upd_taken_i && upd_loop != upd_taken_i) begin
      if (upd_old.arb != '0) upd_new.arb = upd_old.arb - ARB_BITS'(1);
    end
    if (upd_taken_i == upd_old.last_taken) begin
      if (upd_old.trip != '1) upd_new.trip = upd_old.trip + LOOP_BITS'(1);
    end else begin
      upd_new.trip = LOOP_BITS'(1);
      if (upd_old.last_taken == upd_old.longest_taken) begin
        upd_new.longest = upd_old.trip;
      end else if (upd_old.trip > upd_old.longest) begin
        upd_new.longest       = upd_old.trip;
        upd_new.longest_taken = upd_old.last_taken;
      end
    end
    upd_new.last_taken = upd_taken_i;
`endif
  end

  // Table storage: no reset so it can map onto RAM; the sweep initialises it
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
        table_q[sweep_q][i] <= default_entry();
      end
    end else if (upd_en) begin
      table_q[upd_row][upd_slot] <= upd_new;
    end
  end

endmodule
